bcd_to_bin_seq: RTL and testbench
=================================

# bcd_to_bin_seq

Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from any BCD digit field that is 8 or more. It is the return path for the binary-to-BCD code converters. It takes packed BCD digits from keypad or display-entry logic and produces a plain binary value for arithmetic blocks. It uses one shift step per cycle with a start/busy/done handshake, which keeps it small enough to sit beside the combinational converters.

## Interface
- DIGITS, 3, number of packed BCD digits on bcd_in.
- BIN_W, 10, binary result width. Must satisfy 2^BIN_W >= 10^DIGITS; a smaller value is a configuration error.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request conversion of bcd_in. Accepted only in IDLE or DONE.
- bcd_in  input  4*DIGITS  packed BCD, digit 0 in [3:0]. Sampled only on the accepting edge.
- busy  output  1  high while in SHIFT.
- done  output  1  high for exactly one cycle (state DONE) when bin_out is valid and new.
- bin_out  output  BIN_W  binary result. Held stable until the next conversion completes.
- err  output  1  invalid-digit flag (see Configuration).

## Operation
- Internal shift register sr, width 4*DIGITS+BIN_W. Step counter cnt, range 0..BIN_W-1.
- States:
  - IDLE: waiting for start.
  - SHIFT: one conversion step per cycle.
  - DONE: result presented for one cycle.
- Load (start accepted): sr <= {bcd_in, BIN_W zeros}; cnt <= 0; state goes to SHIFT.
- SHIFT step, performed in one cycle:
  - Logically shift sr right by 1.
  - Then, for each digit field sr[BIN_W+4k+3 : BIN_W+4k] that is >= 8, subtract 3 from that field. Fields are handled independently and there is no borrow between them.
- SHIFT exit: after the step with cnt == BIN_W-1, bin_out <= sr_next[BIN_W-1:0] and state goes to DONE. Otherwise cnt increments.
- DONE: done=1 for this cycle, then the next state is IDLE. If start is high in DONE, it is accepted and the next state is SHIFT (back-to-back conversions).
- start high while in SHIFT is ignored. It is not queued and bcd_in is not sampled.
- Arithmetic: unsigned only. Digit corrections are 4-bit wide and cannot underflow, since the field is >= 8 before subtracting.

## Timing
- Reset values: state IDLE, busy 0, done 0, bin_out 0, err 0, sr 0, cnt 0. Reset takes effect immediately and asynchronously, including in the middle of a conversion. The partial result is discarded and bin_out returns to 0.
- Latency, counting from the edge E0 that accepts start:
  - busy is high from after E0 until after edge E(BIN_W).
  - Steps execute on edges E1..E(BIN_W).
  - bin_out updates on E(BIN_W).
  - done is high during the cycle after E(BIN_W).
- With default parameters, done is seen 10 cycles after the start edge. Throughput is one conversion per BIN_W+1 cycles when back-to-back.
- done and busy are never high together.

## Configuration
- BCD_ERR_CHECK_EN defined:
  - On the load edge, any bcd_in digit greater than 9 sets an invalid flag.
  - The block skips SHIFT: state goes to DONE on E1, with bin_out <= 0 and err <= 1.
  - A valid load clears err to 0. err holds until the next accepted start.
- BCD_ERR_CHECK_EN undefined:
  - err is tied to 0.
  - Invalid digits go through the normal BIN_W steps. The result is deterministic but has no defined meaning.

## Test plan
- bcd_in=12'h000, start pulse -> after BIN_W cycles done=1 for one cycle, bin_out=10'd0, err=0.
- bcd_in=12'h999 -> bin_out=10'd999 (0x3E7), with done exactly 10 cycles after the start edge. Repeat with 12'h255 -> 0x0FF, 12'h100 -> 0x064, and 12'h001 -> 0x001.
- start pulsed again at step 4 with bcd_in=12'h123 while converting 12'h456 -> the second start is ignored, bin_out=456 (0x1C8), and busy never drops early.
- start held high through DONE after 12'h042 -> done shows 42 (0x02A), and a second conversion starts immediately with busy high on the next cycle.
- rst asserted at step 5 of 12'h999 -> busy, done, and bin_out are 0 immediately. A new start with 12'h007 afterwards gives 7.
- With BCD_ERR_CHECK_EN, bcd_in=12'h1A3 -> done one cycle after the start edge, err=1, bin_out=0. A following 12'h010 gives err=0 and bin_out=10. Without the macro, err stays 0.

Source files
------------

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: sequential reverse double-dabble BCD-to-binary converter, one shift step per cycle.
// Define BCD_ERR_CHECK_EN to flag digits above 9 and skip the conversion with err set.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);
    localparam int SW = 4*DIGITS + BIN_W;
    localparam int CW = BIN_W > 1 ? $clog2(BIN_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);

    if ((longint'(1) << BIN_W) < (longint'(10) ** DIGITS)) begin : g_cfg_err
        $error("bcd_to_bin_seq: BIN_W too small to hold 10**DIGITS-1");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_next;
    logic [SW-1:0]   sr, sh, sr_next;
    logic [CW-1:0]   cnt;
    logic            accept, last, skip;

    // Shift right, then pull every digit field that landed at 8 or more back by 3.
    always_comb begin
        sh      = sr >> 1;
        sr_next = sh;
        for (int k = 0; k < DIGITS; k++)
            if (sh[BIN_W+4*k+3]) sr_next[BIN_W+4*k +: 4] = sh[BIN_W+4*k +: 4] - 4'd3;
    end

    always_comb begin
        accept     = start && (state == IDLE || state == DONE);
        last       = cnt == LAST || skip;
        state_next = accept ? SHIFT : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
        busy       = state == SHIFT;
        done       = state == DONE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            cnt     <= '0;
            bin_out <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                sr  <= {bcd_in, {BIN_W{1'b0}}};
                cnt <= '0;
            end else if (busy) begin
                sr  <= sr_next;
                cnt <= last ? '0 : cnt + 1'b1;
                if (last) bin_out <= skip ? '0 : sr_next[BIN_W-1:0];
            end
        end

`ifdef BCD_ERR_CHECK_EN
    logic bad_in;

    always_comb begin
        bad_in = 1'b0;
        for (int k = 0; k < DIGITS; k++)
            bad_in = bad_in | (bcd_in[4*k +: 4] > 4'd9);
    end

    // skip remembers an invalid load so the single SHIFT cycle ends the conversion.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            skip <= 1'b0;
            err  <= 1'b0;
        end else if (accept) begin
            skip <= bad_in;
            err  <= 1'b0;
        end else if (busy && skip) begin
            err <= 1'b1;
        end
`else
    assign skip = 1'b0;
    assign err  = 1'b0;
`endif
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed and random checks of bcd_to_bin_seq against a decimal-arithmetic model.
module tb_bcd_to_bin_seq;
    localparam int D = 3;
    localparam int W = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [4*D-1:0] bcd_in = '0;
    logic           busy, done, err;
    logic [W-1:0]   bin_out;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    bcd_to_bin_seq #(.DIGITS(D), .BIN_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
        .busy(busy), .done(done), .bin_out(bin_out), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int ref_bin(input logic [4*D-1:0] v);
        int r = 0;
        for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [4*D-1:0] v);
        @(negedge clk);
        bcd_in = v;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bcd_in = (4*D)'($urandom);
    endtask

    // Starts one cycle after the accepting edge; counts cycles until done.
    task automatic wait_done(input int poke_at, input logic [4*D-1:0] poke_v, input int exp_lat,
                             input logic [31:0] exp_bin, input bit chk_bin, input logic exp_err);
        int lat = 0;
        bit busy_ok = busy && !done;
        for (int i = 1; i <= 40; i++) begin
            start = (i == poke_at);
            if (i == poke_at) bcd_in = poke_v;
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
            busy_ok = busy_ok && busy;
        end
        start = 1'b0;
        check("latency", lat, exp_lat);
        check("busy_span", {31'b0, busy_ok}, 1);
        check("busy_in_done", {31'b0, busy}, 0);
        if (chk_bin) check("bin_out", {22'b0, bin_out}, exp_bin);
        check("err", {31'b0, err}, {31'b0, exp_err});
    endtask

    task automatic conv(input logic [4*D-1:0] v);
        launch(v);
        wait_done(0, '0, W, ref_bin(v), 1'b1, 1'b0);
        @(negedge clk);
        check("done_pulse", {31'b0, done}, 0);
        check("bin_hold", {22'b0, bin_out}, ref_bin(v));
    endtask

    initial begin
        logic [4*D-1:0] v;
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_bin", {22'b0, bin_out}, 0);
        check("rst_err", {31'b0, err}, 0);
        @(negedge clk);
        rst = 1'b0;

        conv(12'h000);
        conv(12'h999);
        conv(12'h255);
        conv(12'h100);
        conv(12'h001);
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < D; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
            conv(v);
        end

        launch(12'h456);
        wait_done(4, 12'h123, W, ref_bin(12'h456), 1'b1, 1'b0);

        launch(12'h042);
        wait_done(0, '0, W, ref_bin(12'h042), 1'b1, 1'b0);
        start  = 1'b1;
        bcd_in = 12'h300;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", {31'b0, busy}, 1);
        check("b2b_done", {31'b0, done}, 0);
        wait_done(0, '0, W, ref_bin(12'h300), 1'b1, 1'b0);

        launch(12'h999);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 0);
        check("arst_done", {31'b0, done}, 0);
        check("arst_bin", {22'b0, bin_out}, 0);
        @(negedge clk);
        rst = 1'b0;
        conv(12'h007);

`ifdef BCD_ERR_CHECK_EN
        launch(12'h1A3);
        wait_done(0, '0, 1, 0, 1'b1, 1'b1);
        launch(12'h010);
        wait_done(0, '0, W, 10, 1'b1, 1'b0);
`else
        launch(12'h1A3);
        wait_done(0, '0, W, 0, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
